// File: rtl/cpu_bus1_responder.sv
// Cache-side responder for CPU<->cache bus 1 (C1 command, A1 address, D1 data).
// Collects the two-cycle command/address (+ write data), issues one request
// to the cache core over valid/ready, then answers on the shared bus with
// C1_RESPONSE (+ read data) and a one-cycle NOP before releasing C1/D1.
//
// Ports:
//   clk, rst_n        clock (posedge), asynchronous active-low reset
//   A1                CPU address bus (tag/set in cycle 1, offset in cycle 2)
//   C1, D1            shared command/data buses, driven only while responding
//   req_valid/ready   request handshake to the cache core
//   req_op/addr/wdata request fields, stable while req_valid is high
//   resp_valid/rdata  core completion pulse and read data
//   txn_cnt           completed-transaction counter (wraps)
module cpu_bus1_responder #(
   parameter int ADDR1_BUS_SIZE  = 15,
   parameter int DATA_BUS_SIZE   = 16,
   parameter int CTR1_BUS_SIZE   = 3,
   parameter int OFFSET_SIZE     = 4,
   parameter int CACHE_ADDR_SIZE = ADDR1_BUS_SIZE + OFFSET_SIZE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR1_BUS_SIZE-1:0]  A1,
   inout  wire  [CTR1_BUS_SIZE-1:0]   C1,
   inout  wire  [DATA_BUS_SIZE-1:0]   D1,
   output logic                       req_valid,
   input  logic                       req_ready,
   output logic [2:0]                 req_op,
   output logic [CACHE_ADDR_SIZE-1:0] req_addr,
   output logic [31:0]                req_wdata,
   input  logic                       resp_valid,
   input  logic [31:0]                resp_rdata,
   output logic [31:0]                txn_cnt
);

   localparam logic [CTR1_BUS_SIZE-1:0] OP_NOP     = 3'd0;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_READ8   = 3'd1;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_READ16  = 3'd2;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_READ32  = 3'd3;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_INV     = 3'd4;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_WRITE8  = 3'd5;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_WRITE16 = 3'd6;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_WRITE32 = 3'd7;
   localparam logic [CTR1_BUS_SIZE-1:0] OP_RESP    = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR2,
      S_ISSUE,
      S_WAIT,
      S_RESP1,
      S_RESP2,
      S_REL
   } state_t;

   state_t                    state_q, state_d;
   logic [CTR1_BUS_SIZE-1:0]  op_q, op_d;
   logic [ADDR1_BUS_SIZE-1:0] tagset_q, tagset_d;
   logic [OFFSET_SIZE-1:0]    off_q, off_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [31:0]               rdata_q, rdata_d;
   logic [31:0]               cnt_q, cnt_d;

   logic                      cmd_v;
   logic                      cmd_wr;
   logic                      op_rd;
   logic                      c1_oe;
   logic [CTR1_BUS_SIZE-1:0]  c1_out;
   logic                      d1_oe;
   logic [DATA_BUS_SIZE-1:0]  d1_out;

   // Case equality keeps X/Z on C1 out of every command item, so they
   // fall to the default and read as NOP.
   always_comb begin
      cmd_v  = 1'b0;
      cmd_wr = 1'b0;
      case (C1)
         OP_READ8, OP_READ16, OP_READ32, OP_INV: cmd_v = 1'b1;
         OP_WRITE8, OP_WRITE16, OP_WRITE32: begin
            cmd_v  = 1'b1;
            cmd_wr = 1'b1;
         end
         default: ;
      endcase
   end

   assign op_rd = (op_q == OP_READ8) || (op_q == OP_READ16) ||
                  (op_q == OP_READ32);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         tagset_q <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tagset_q <= tagset_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tagset_d = tagset_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      c1_oe    = 1'b0;
      c1_out   = OP_NOP;
      d1_oe    = 1'b0;
      d1_out   = '0;
      case (state_q)
         S_IDLE: begin
            if (cmd_v) begin
               op_d     = C1;
               tagset_d = A1;
               off_d    = '0;
               wdata_d  = cmd_wr ? {16'h0000, D1} : 32'h0;
               state_d  = (C1 == OP_INV) ? S_ISSUE : S_ADDR2;
            end
         end
         S_ADDR2: begin
            off_d = A1[OFFSET_SIZE-1:0];
            case (op_q)
               OP_READ16, OP_WRITE16: off_d[0] = 1'b0;
               OP_READ32, OP_WRITE32: off_d[1:0] = 2'b00;
               default: ;
            endcase
            case (op_q)
               OP_WRITE8:  wdata_d = {24'h0, wdata_q[7:0]};
               OP_WRITE16: wdata_d = {16'h0, wdata_q[15:0]};
               OP_WRITE32: wdata_d = {D1, wdata_q[15:0]};
               default: ;
            endcase
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            // A completion arriving with the handshake skips WAIT.
            if (req_ready) begin
               if (resp_valid) begin
                  rdata_d = resp_rdata;
                  state_d = S_RESP1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (resp_valid) begin
               rdata_d = resp_rdata;
               state_d = S_RESP1;
            end
         end
         S_RESP1: begin
            c1_oe   = 1'b1;
            c1_out  = OP_RESP;
            d1_oe   = op_rd;
            d1_out  = rdata_q[15:0];
            state_d = (op_q == OP_READ32) ? S_RESP2 : S_REL;
         end
         S_RESP2: begin
            c1_oe   = 1'b1;
            c1_out  = OP_RESP;
            d1_oe   = 1'b1;
            d1_out  = rdata_q[31:16];
            state_d = S_REL;
         end
         S_REL: begin
            c1_oe   = 1'b1;
            c1_out  = OP_NOP;
            cnt_d   = cnt_q + 32'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign C1 = c1_oe ? c1_out : {CTR1_BUS_SIZE{1'bz}};
   assign D1 = d1_oe ? d1_out : {DATA_BUS_SIZE{1'bz}};

   assign req_valid = (state_q == S_ISSUE);
   assign req_op    = op_q;
   assign req_addr  = {tagset_q, off_q};
   assign req_wdata = wdata_q;
   assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_bus1_responder.sv
// Directed bench for cpu_bus1_responder: table of bus transactions plus
// hand-written backpressure, same-cycle completion and reset-in-WAIT cases.
module tb_cpu_bus1_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [14:0] A1;
   logic [2:0]  c1_drv;
   logic        c1_en;
   logic [15:0] d1_drv;
   logic        d1_en;
   wire  [2:0]  C1;
   wire  [15:0] D1;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [18:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [31:0] txn_cnt;

   assign C1 = c1_en ? c1_drv : 3'bzzz;
   assign D1 = d1_en ? d1_drv : 16'hzzzz;

   wire c1_z = (C1 === 3'bzzz);
   wire d1_z = (D1 === 16'hzzzz);

   cpu_bus1_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A1         (A1),
      .C1         (C1),
      .D1         (D1),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .txn_cnt    (txn_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [14:0] a_hi;
      logic [3:0]  a_off;
      logic [15:0] d_lo;
      logic [15:0] d_hi;
      logic [31:0] rdata;
      logic [18:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_dz;
      logic [15:0] e_d1a;
      logic [15:0] e_d1b;
   } vec_t;

   vec_t vecs[7];

   // Entered and left at a negedge with the DUT in IDLE. Core accepts at
   // once and completes in the WAIT cycle, so RESPONSE shows up 3 cycles
   // after the command cycle for INV and 4 for the rest.
   task automatic run_txn(input vec_t v, input logic [31:0] e_cnt);
      c1_en = 1'b1; c1_drv = v.op; A1 = v.a_hi;
      d1_en = 1'b1; d1_drv = v.d_lo;
      req_ready = 1'b1; resp_valid = 1'b0;
      @(negedge clk);
      c1_en = 1'b0;
      if (v.op != 3'd4) begin
         chk("addr2_valid", req_valid, 0);
         A1 = {11'h0, v.a_off}; d1_drv = v.d_hi;
         @(negedge clk);
      end
      d1_en = 1'b0;
      chk("issue_valid", req_valid, 1);
      chk("issue_op", req_op, v.op);
      chk("issue_addr", req_addr, v.e_addr);
      chk("issue_wdata", req_wdata, v.e_wdata);
      @(negedge clk);
      chk("wait_valid", req_valid, 0);
      chk("wait_c1_z", c1_z, 1);
      resp_valid = 1'b1; resp_rdata = v.rdata;
      @(negedge clk);
      resp_valid = 1'b0;
      chk("resp1_c1", C1, 3'd7);
      if (v.e_dz) chk("resp1_d1_z", d1_z, 1);
      else chk("resp1_d1", D1, v.e_d1a);
      if (v.op == 3'd3) begin
         @(negedge clk);
         chk("resp2_c1", C1, 3'd7);
         chk("resp2_d1", D1, v.e_d1b);
      end
      @(negedge clk);
      chk("rel_c1", C1, 3'd0);
      chk("rel_d1_z", d1_z, 1);
      @(negedge clk);
      chk("idle_c1_z", c1_z, 1);
      chk("idle_d1_z", d1_z, 1);
      chk("txn_cnt", txn_cnt, e_cnt);
   endtask

   initial begin
      vec_t rv;
      vecs[0] = '{op:3'd1, a_hi:15'h0040, a_off:4'h3, d_lo:16'h0,
                  d_hi:16'h0, rdata:32'h000000AB, e_addr:19'h00403,
                  e_wdata:32'h0, e_dz:1'b0, e_d1a:16'h00AB, e_d1b:16'h0};
      vecs[1] = '{op:3'd3, a_hi:15'h0123, a_off:4'h7, d_lo:16'h0,
                  d_hi:16'h0, rdata:32'hDEADBEEF, e_addr:19'h01234,
                  e_wdata:32'h0, e_dz:1'b0, e_d1a:16'hBEEF,
                  e_d1b:16'hDEAD};
      vecs[2] = '{op:3'd7, a_hi:15'h2AAA, a_off:4'h5, d_lo:16'h1234,
                  d_hi:16'h5678, rdata:32'hFFFFFFFF, e_addr:19'h2AAA4,
                  e_wdata:32'h56781234, e_dz:1'b1, e_d1a:16'h0,
                  e_d1b:16'h0};
      vecs[3] = '{op:3'd4, a_hi:15'h7FFF, a_off:4'h0, d_lo:16'h0,
                  d_hi:16'h0, rdata:32'h0, e_addr:19'h7FFF0,
                  e_wdata:32'h0, e_dz:1'b1, e_d1a:16'h0, e_d1b:16'h0};
      vecs[4] = '{op:3'd5, a_hi:15'h0001, a_off:4'hF, d_lo:16'hBEEF,
                  d_hi:16'h9999, rdata:32'h0, e_addr:19'h0001F,
                  e_wdata:32'h000000EF, e_dz:1'b1, e_d1a:16'h0,
                  e_d1b:16'h0};
      vecs[5] = '{op:3'd6, a_hi:15'h0002, a_off:4'h9, d_lo:16'hCAFE,
                  d_hi:16'h1111, rdata:32'h0, e_addr:19'h00028,
                  e_wdata:32'h0000CAFE, e_dz:1'b1, e_d1a:16'h0,
                  e_d1b:16'h0};
      vecs[6] = '{op:3'd2, a_hi:15'h0003, a_off:4'hB, d_lo:16'h0,
                  d_hi:16'h0, rdata:32'hFFFF8765, e_addr:19'h0003A,
                  e_wdata:32'h0, e_dz:1'b0, e_d1a:16'h8765,
                  e_d1b:16'h0};

      rst_n = 1'b0; A1 = '0; c1_en = 1'b0; c1_drv = '0;
      d1_en = 1'b0; d1_drv = '0; req_ready = 1'b0;
      resp_valid = 1'b0; resp_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_c1_z", c1_z, 1);
      chk("rst_d1_z", d1_z, 1);
      chk("rst_valid", req_valid, 0);
      chk("rst_op", req_op, 0);
      chk("rst_addr", req_addr, 0);
      chk("rst_wdata", req_wdata, 0);
      chk("rst_cnt", txn_cnt, 0);
      rst_n = 1'b1;

      // NOP and an undriven bus must not start a transaction
      c1_en = 1'b1; c1_drv = 3'd0; req_ready = 1'b1;
      @(negedge clk);
      c1_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("nop_valid", req_valid, 0);
      chk("nop_c1_z", c1_z, 1);

      for (int i = 0; i < 7; i++) run_txn(vecs[i], 32'(i + 1));

      // Backpressure: READ16, ready low 5 cycles, stray resp_valid in ISSUE
      req_ready = 1'b0;
      c1_en = 1'b1; c1_drv = 3'd2; A1 = 15'h0155;
      @(negedge clk);
      c1_en = 1'b0; A1 = 15'h0003;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", req_valid, 1);
         chk("bp_op", req_op, 3'd2);
         chk("bp_addr", req_addr, 19'h01552);
         chk("bp_wdata", req_wdata, 32'h0);
         resp_valid = (i == 2); resp_rdata = 32'hBAD0BAD0;
         A1 = 15'h7ABC;
         @(negedge clk);
      end
      resp_valid = 1'b0;
      chk("bp_hold_valid", req_valid, 1);
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      chk("bp_wait_valid", req_valid, 0);
      chk("bp_wait_c1_z", c1_z, 1);
      @(negedge clk);
      chk("bp_wait2_c1_z", c1_z, 1);
      resp_valid = 1'b1; resp_rdata = 32'h00004321;
      @(negedge clk);
      resp_valid = 1'b0;
      chk("bp_resp_c1", C1, 3'd7);
      chk("bp_resp_d1", D1, 16'h4321);
      @(negedge clk);
      chk("bp_rel_c1", C1, 3'd0);
      @(negedge clk);
      chk("bp_cnt", txn_cnt, 8);

      // Completion in the same cycle as the handshake (INV)
      c1_en = 1'b1; c1_drv = 3'd4; A1 = 15'h1234; req_ready = 1'b1;
      @(negedge clk);
      c1_en = 1'b0;
      chk("sc_addr", req_addr, 19'h12340);
      resp_valid = 1'b1; resp_rdata = 32'h0;
      @(negedge clk);
      resp_valid = 1'b0;
      chk("sc_resp_c1", C1, 3'd7);
      chk("sc_resp_d1_z", d1_z, 1);
      @(negedge clk);
      chk("sc_rel_c1", C1, 3'd0);
      @(negedge clk);
      chk("sc_cnt", txn_cnt, 9);

      // Reset while in WAIT drops the transaction
      c1_en = 1'b1; c1_drv = 3'd1; A1 = 15'h0011;
      @(negedge clk);
      c1_en = 1'b0; A1 = 15'h0001;
      @(negedge clk);
      @(negedge clk);
      chk("rw_wait_valid", req_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("rw_c1_z", c1_z, 1);
      chk("rw_d1_z", d1_z, 1);
      chk("rw_valid", req_valid, 0);
      chk("rw_cnt", txn_cnt, 0);
      chk("rw_addr", req_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rw_idle_c1_z", c1_z, 1);
      rv = '{op:3'd2, a_hi:15'h0077, a_off:4'h5, d_lo:16'h0, d_hi:16'h0,
             rdata:32'h0000A5A5, e_addr:19'h00774, e_wdata:32'h0,
             e_dz:1'b0, e_d1a:16'hA5A5, e_d1b:16'h0};
      run_txn(rv, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
